// File: rtl/rv32i_wbarbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared types and constants for the register-file writeback
//                arbiter. Defines the writeback request record carried
//                through the late-response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // One register-file write: destination register and data.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/rv32i_wbarbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_wbFifo
//  Description : Synchronous FIFO of writeback requests. Pointers carry an
//                extra wrap bit so full and empty are distinguished without
//                a separate occupancy counter.
//  Ports       : clk, reset_n      - clock, async active-low reset
//                push, push_data   - write an entry (ignored when full)
//                pop               - discard the head (ignored when empty)
//                head              - current head entry (valid when !empty)
//                full, empty       - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_wbFifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with opposite wrap bits means every slot is occupied.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule : rv32i_wbFifo
`default_nettype wire

// File: rtl/rv32i_wbarbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_wbarbiter
//  Description : Owns the single register-file write port. Pipeline
//                writebacks always win; late load/IO responses are queued
//                and drained when the pipeline is idle. An age counter
//                forces a pipeline stall so queued responses cannot starve.
//                Also keeps a pending-write scoreboard for hazard detection.
//  Ports       : clk, reset_n                    - clock, async active-low reset
//                pipe_wb_en/reg/data             - pipeline writeback request
//                late_issue, late_issue_reg      - late op issued (sets pending)
//                late_valid/reg/data, late_ready - late response handshake
//                rf_wb_en/reg/data               - registered RF write port
//                stall                           - registered pipeline stall
//                pending_mask                    - outstanding late writes
//                err_dup_issue                   - sticky duplicate-issue flag
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_wbarbiter
  import rv32i_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pipe_wb_en,
  input  logic [REG_W-1:0] pipe_wb_reg,
  input  logic [XLEN-1:0]  pipe_wb_data,
  input  logic             late_issue,
  input  logic [REG_W-1:0] late_issue_reg,
  input  logic             late_valid,
  input  logic [REG_W-1:0] late_reg,
  input  logic [XLEN-1:0]  late_data,
  output logic             late_ready,
  output logic             rf_wb_en,
  output logic [REG_W-1:0] rf_wb_reg,
  output logic [XLEN-1:0]  rf_wb_data,
  output logic             stall,
  output logic [XLEN-1:0]  pending_mask,
  output logic             err_dup_issue
);

  localparam logic [7:0] MAX_AGE = 8'(MAX_WAIT);

  wb_req_t          push_req;
  wb_req_t          fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       age;
  logic [XLEN-1:0]  pending_next;

  // A full FIFO never accepts, even in a cycle where the head is popped.
  assign late_ready = !fifo_full;
  assign fifo_push  = late_valid && !fifo_full;
  assign fifo_pop   = !pipe_wb_en && !fifo_empty;

  assign push_req.rd   = late_reg;
  assign push_req.data = late_data;

  rv32i_wbFifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scoreboard update: commit clears first so a same-cycle issue wins.
  always_comb begin
    pending_next = pending_mask;
    if (fifo_pop)   pending_next[fifo_head.rd] = 1'b0;
    if (late_issue) pending_next[late_issue_reg] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wb_en      <= 1'b0;
      rf_wb_reg     <= '0;
      rf_wb_data    <= '0;
      stall         <= 1'b0;
      age           <= '0;
      pending_mask  <= '0;
      err_dup_issue <= 1'b0;
    end else begin
      // Write port: x0 targets are granted (and consumed) but never written.
      if (pipe_wb_en) begin
        rf_wb_en   <= (pipe_wb_reg != '0);
        rf_wb_reg  <= pipe_wb_reg;
        rf_wb_data <= pipe_wb_data;
      end else if (fifo_pop) begin
        rf_wb_en   <= (fifo_head.rd != '0);
        rf_wb_reg  <= fifo_head.rd;
        rf_wb_data <= fifo_head.data;
      end else begin
        rf_wb_en   <= 1'b0;
      end

      // Age counts cycles a queued head is denied the write port.
      if (fifo_pop || fifo_empty) begin
        age <= '0;
      end else if (age != MAX_AGE) begin
        age <= age + 8'd1;
      end

      stall <= fifo_full || (age == MAX_AGE);

      pending_mask <= pending_next;
      if (late_issue && pending_mask[late_issue_reg]) begin
        err_dup_issue <= 1'b1;
      end
    end
  end

endmodule : rv32i_wbarbiter
`default_nettype wire
